// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the two-port Wishbone arbiter.
package wb_arb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SEL_W  = 4;

  // Request fields captured at strobe time and replayed at issue.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_wr;
    logic [SEL_W-1:0]  sel;
    logic              we;
  } wb_req_t;

  // Counter width able to hold a watchdog load value of `cycles`.
  function automatic int unsigned timeout_w(input int unsigned cycles);
    int unsigned w;
    w = 32'($clog2(64'(cycles) + 64'd1));
    return (w < 32'd1) ? 32'd1 : w;
  endfunction

endpackage

// File: rtl/wb_req_slot.sv
// One-entry holding register for a strobe that could not be issued at once.
module wb_req_slot
  import wb_arb_pkg::*;
(
  input  logic    i_clk,
  input  logic    i_rst,
  input  logic    i_load,
  input  logic    i_clr,
  input  wb_req_t i_req,
  output logic    o_valid,
  output wb_req_t o_req
);

  logic    valid_q, valid_d;
  wb_req_t req_q, req_d;

  // Load wins over clear; the two never coincide for a well-behaved port.
  always_comb begin
    valid_d = valid_q;
    req_d   = req_q;
    if (i_clr) begin
      valid_d = 1'b0;
    end
    if (i_load) begin
      valid_d = 1'b1;
      req_d   = i_req;
    end
  end

  // Slot state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      req_q   <= '0;
    end else begin
      valid_q <= valid_d;
      req_q   <= req_d;
    end
  end

  assign o_valid = valid_q;
  assign o_req   = req_q;

endmodule

// File: rtl/wb_arbiter2.sv
// Round-robin arbiter sharing one Wishbone target between fetch (port 0)
// and data (port 1) controllers, with per-port replay slots and a watchdog.
module wb_arbiter2
  import wb_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_wb0_cyc,
  input  logic        i_wb0_stb,
  input  logic        i_wb0_we,
  input  logic [31:0] i_wb0_addr,
  input  logic [31:0] i_wb0_data_wr,
  input  logic [3:0]  i_wb0_sel,
  output logic        o_wb0_ack_c,
  output logic        o_wb0_err_c,
  output logic [31:0] o_wb0_data_rd_c,
  input  logic        i_wb1_cyc,
  input  logic        i_wb1_stb,
  input  logic        i_wb1_we,
  input  logic [31:0] i_wb1_addr,
  input  logic [31:0] i_wb1_data_wr,
  input  logic [3:0]  i_wb1_sel,
  output logic        o_wb1_ack_c,
  output logic        o_wb1_err_c,
  output logic [31:0] o_wb1_data_rd_c,
  output logic        o_wbt_cyc_c,
  output logic        o_wbt_stb_c,
  output logic        o_wbt_we_c,
  output logic [31:0] o_wbt_addr_c,
  output logic [31:0] o_wbt_data_wr_c,
  output logic [3:0]  o_wbt_sel_c,
  input  logic        i_wbt_ack,
  input  logic        i_wbt_err,
  input  logic [31:0] i_wbt_data_rd,
  output logic        o_owner,
  output logic        o_busy,
  output logic        o_timeout
);

  localparam int unsigned TW      = timeout_w(TIMEOUT_CYCLES);
  // Counter holds cycles remaining minus one so it fires exactly at zero.
  localparam int unsigned WD_INIT = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam bit          WD_EN   = (TIMEOUT_CYCLES != 0);

  logic          busy_q, busy_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic [TW-1:0] wd_q, wd_d;
  wb_req_t       req_q, req_d;

  wb_req_t port0_req, port1_req, slot0_req, slot1_req, issue_req;
  logic    slot0_vld, slot1_vld;
  logic    stb0, stb1, want0, want1;
  logic    live, resp, fire, free, issue, gnt;
  logic    load0, load1, clr0, clr1;

  // Gather the live port fields into request structs.
  always_comb begin
    port0_req.addr    = i_wb0_addr;
    port0_req.data_wr = i_wb0_data_wr;
    port0_req.sel     = i_wb0_sel;
    port0_req.we      = i_wb0_we;
    port1_req.addr    = i_wb1_addr;
    port1_req.data_wr = i_wb1_data_wr;
    port1_req.sel     = i_wb1_sel;
    port1_req.we      = i_wb1_we;
  end

  // Grant decision: a strobe during reset is dropped; ties go to the other port.
  always_comb begin
    stb0      = ~i_rst & i_wb0_stb & i_wb0_cyc;
    stb1      = ~i_rst & i_wb1_stb & i_wb1_cyc;
    want0     = stb0 | (slot0_vld & ~i_rst);
    want1     = stb1 | (slot1_vld & ~i_rst);
    live      = busy_q & ~i_rst;
    resp      = live & (i_wbt_ack | i_wbt_err);
    fire      = WD_EN & live & ~(i_wbt_ack | i_wbt_err) & (wd_q == '0);
    free      = ~i_rst & (~busy_q | i_wbt_ack | i_wbt_err);
    issue     = free & (want0 | want1);
    gnt       = want1 & (~want0 | ~last_q);
    issue_req = gnt ? (slot1_vld ? slot1_req : port1_req)
                    : (slot0_vld ? slot0_req : port0_req);
    clr0      = issue & ~gnt;
    clr1      = issue & gnt;
    load0     = stb0 & ~clr0;
    load1     = stb1 & ~clr1;
  end

  // Transaction tracking: issue loads state, completion or timeout releases it.
  always_comb begin
    busy_d  = busy_q;
    owner_d = owner_q;
    last_d  = last_q;
    req_d   = req_q;
    wd_d    = wd_q;
    if (issue) begin
      busy_d  = 1'b1;
      owner_d = gnt;
      last_d  = gnt;
      req_d   = issue_req;
      wd_d    = TW'(WD_INIT);
    end else begin
      if (resp | fire) begin
        busy_d = 1'b0;
      end
      if (live && (wd_q != '0)) begin
        wd_d = wd_q - TW'(1);
      end
    end
  end

  // Arbiter state registers; last grant resets to port 1 so port 0 wins first.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      busy_q  <= 1'b0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      req_q   <= '0;
      wd_q    <= '0;
    end else begin
      busy_q  <= busy_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      req_q   <= req_d;
      wd_q    <= wd_d;
    end
  end

  wb_req_slot u_slot0 (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (load0),
    .i_clr   (clr0),
    .i_req   (port0_req),
    .o_valid (slot0_vld),
    .o_req   (slot0_req)
  );

  wb_req_slot u_slot1 (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (load1),
    .i_clr   (clr1),
    .i_req   (port1_req),
    .o_valid (slot1_vld),
    .o_req   (slot1_req)
  );

  // Target drive and response routing; responses reach the owner only.
  always_comb begin
    o_wbt_cyc_c     = live | issue;
    o_wbt_stb_c     = issue;
    o_wbt_addr_c    = issue ? issue_req.addr    : req_q.addr;
    o_wbt_data_wr_c = issue ? issue_req.data_wr : req_q.data_wr;
    o_wbt_sel_c     = issue ? issue_req.sel     : req_q.sel;
    o_wbt_we_c      = issue ? issue_req.we      : req_q.we;
    o_wb0_ack_c     = live & ~owner_q & i_wbt_ack;
    o_wb0_err_c     = live & ~owner_q & (i_wbt_err | fire);
    o_wb1_ack_c     = live & owner_q & i_wbt_ack;
    o_wb1_err_c     = live & owner_q & (i_wbt_err | fire);
    o_wb0_data_rd_c = i_wbt_data_rd;
    o_wb1_data_rd_c = i_wbt_data_rd;
    o_owner         = ~i_rst & owner_q;
    o_busy          = live;
    o_timeout       = fire;
  end

endmodule
